// File: rtl/alu_pkg.sv
// Package shared by the sequential ALU, its bus interface and the bench.
// Contents:
//   ALU_OP_W     opcode width
//   alu_op_t     4-bit opcode encoding (values 9..15 are illegal)
//   alu_flags_t  packed {z, n, c, v} result flag set
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_CLR  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_PASS = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_MUL  = 4'd6,
        OP_DIV  = 4'd7,
        OP_REM  = 4'd8
    } alu_op_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result bus between the register file, the sequential ALU and the
// C-bus writeback stage.
//   master : upstream/consumer side (drives InValid, Operation, BusA, BusB,
//            ShAmt, OutReady; observes InReady, OutValid, BusC, flags)
//   slave  : the ALU itself
interface alu_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
);
    logic                InValid;
    logic                InReady;
    logic [ALU_OP_W-1:0] Operation;
    logic [WIDTH-1:0]    BusA;
    logic [WIDTH-1:0]    BusB;
    logic [SHW-1:0]      ShAmt;
    logic                OutValid;
    logic                OutReady;
    logic [WIDTH-1:0]    BusC;
    logic                FlagZ;
    logic                FlagN;
    logic                FlagC;
    logic                FlagV;
    logic                OpIllegal;

    modport master (
        output InValid, Operation, BusA, BusB, ShAmt, OutReady,
        input  InReady, OutValid, BusC, FlagZ, FlagN, FlagC, FlagV, OpIllegal
    );

    modport slave (
        input  InValid, Operation, BusA, BusB, ShAmt, OutReady,
        output InReady, OutValid, BusC, FlagZ, FlagN, FlagC, FlagV, OpIllegal
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative multiplier / divider used by alu_seq.
// Optional feature macro: ALU_SEQ_DIV_EN (restoring divider present when defined).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   start       load operands and begin WIDTH iterations
//   op          opcode at start (selects MUL / DIV / REM)
//   a, b        operands
//   done        high in the cycle whose clock edge completes the last iteration
//   result      final value, valid while done is high
//   divByZero   divisor was zero (only ever set with the divider present)
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                done,
    output logic [WIDTH-1:0]    result,
    output logic                divByZero
);
    localparam int CNT_W = $clog2(WIDTH);

    logic             busyReg;
    logic [CNT_W-1:0] cntReg;
    // MUL: accReg=partial product, xReg=shifting multiplicand, yReg=shifting multiplier
    // DIV: accReg=partial remainder, xReg=dividend/quotient shifter, yReg=divisor
    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] xReg;
    logic [WIDTH-1:0] yReg;

    logic [WIDTH-1:0] mulAcc;
    logic [WIDTH-1:0] mulX;
    logic [WIDTH-1:0] mulY;
    logic [WIDTH-1:0] accNext;
    logic [WIDTH-1:0] xNext;
    logic [WIDTH-1:0] yNext;
    logic             lastIter;

    assign mulAcc   = accReg + (yReg[0] ? xReg : '0);
    assign mulX     = {xReg[WIDTH-2:0], 1'b0};
    assign mulY     = {1'b0, yReg[WIDTH-1:1]};
    assign lastIter = (cntReg == CNT_W'(WIDTH - 1));
    assign done     = busyReg & lastIter;

`ifdef ALU_SEQ_DIV_EN
    logic             divModeReg;
    logic             remModeReg;
    logic             divZeroReg;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH-1:0] divAcc;
    logic [WIDTH-1:0] divX;

    // One restoring step: bring in the next dividend bit, subtract the
    // divisor if it fits. A zero divisor always "fits", which naturally
    // yields an all-ones quotient and a remainder equal to A.
    assign shifted   = {accReg, xReg[WIDTH-1]};
    assign trial     = shifted - {1'b0, yReg};
    assign fits      = ~trial[WIDTH];
    assign divAcc    = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign divX      = {xReg[WIDTH-2:0], fits};
    assign divByZero = divZeroReg;
`else
    logic unusedOp;
    assign unusedOp  = ^op;
    assign divByZero = 1'b0;
`endif

    always_comb begin
        accNext = mulAcc;
        xNext   = mulX;
        yNext   = mulY;
        result  = mulAcc;
`ifdef ALU_SEQ_DIV_EN
        if (divModeReg) begin
            accNext = divAcc;
            xNext   = divX;
            yNext   = yReg;
            result  = remModeReg ? divAcc : divX;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busyReg    <= 1'b0;
            cntReg     <= '0;
            accReg     <= '0;
            xReg       <= '0;
            yReg       <= '0;
`ifdef ALU_SEQ_DIV_EN
            divModeReg <= 1'b0;
            remModeReg <= 1'b0;
            divZeroReg <= 1'b0;
`endif
        end else if (start) begin
            busyReg    <= 1'b1;
            cntReg     <= '0;
            accReg     <= '0;
            xReg       <= a;
            yReg       <= b;
`ifdef ALU_SEQ_DIV_EN
            divModeReg <= (op == OP_DIV) || (op == OP_REM);
            remModeReg <= (op == OP_REM);
            divZeroReg <= (b == '0);
`endif
        end else if (busyReg) begin
            accReg <= accNext;
            xReg   <= xNext;
            yReg   <= yNext;
            if (lastIter) begin
                busyReg <= 1'b0;
                cntReg  <= '0;
            end else begin
                cntReg <= cntReg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU between the register file and the C-bus
// writeback stage. Single-cycle ops: CLR ADD SUB PASS SHL SHR.
// Iterative ops (WIDTH+1 cycles): MUL, and DIV/REM when ALU_SEQ_DIV_EN is
// defined; without that macro opcodes 7/8 complete in one cycle as illegal.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (abandons any operation in flight)
//   bus    alu_seq_if.slave: InValid/InReady operand handshake, Operation,
//          BusA, BusB, ShAmt; OutValid/OutReady result handshake, BusC,
//          FlagZ/N/C/V, OpIllegal
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t           stateReg;
    logic             outValidReg;
    logic [WIDTH-1:0] busCReg;
    alu_flags_t       flagsReg;
    logic             opIllegalReg;

    logic             inReady;
    logic             accept;
    logic             isIter;
    logic [SHW-1:0]   shAmt;

    logic [WIDTH:0]   addWide;
    logic [WIDTH:0]   subWide;
    logic [WIDTH:0]   shlWide;
    logic [WIDTH:0]   shrWide;
    logic [WIDTH-1:0] singleResult;
    logic             singleCarry;
    logic             singleOvf;
    logic             singleIllegal;
    alu_flags_t       singleFlags;

    logic             mdDone;
    logic [WIDTH-1:0] mdResult;
    logic             mdDivByZero;
    alu_flags_t       mdFlags;

    // A finished result may be replaced in the same cycle it is consumed.
    assign inReady = (stateReg == ST_IDLE) | ((stateReg == ST_DONE) & bus.OutReady);
    assign accept  = bus.InValid & inReady;
    assign shAmt   = bus.ShAmt;

    always_comb begin
        isIter = (bus.Operation == OP_MUL);
`ifdef ALU_SEQ_DIV_EN
        isIter = isIter | (bus.Operation == OP_DIV) | (bus.Operation == OP_REM);
`endif
    end

    // The extra MSB of add/sub holds carry/borrow. Shifts use a one-bit
    // extension on the far side so the last bit shifted out lands there;
    // a zero shift leaves that bit clear.
    assign addWide = {1'b0, bus.BusA} + {1'b0, bus.BusB};
    assign subWide = {1'b0, bus.BusA} - {1'b0, bus.BusB};
    assign shlWide = {1'b0, bus.BusA} << shAmt;
    assign shrWide = {bus.BusA, 1'b0} >> shAmt;

    always_comb begin
        singleResult  = '0;
        singleCarry   = 1'b0;
        singleOvf     = 1'b0;
        singleIllegal = 1'b0;
        case (bus.Operation)
            OP_CLR: singleResult = '0;
            OP_ADD: begin
                singleResult = addWide[WIDTH-1:0];
                singleCarry  = addWide[WIDTH];
                singleOvf    = (bus.BusA[WIDTH-1] == bus.BusB[WIDTH-1]) &
                               (addWide[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            OP_SUB: begin
                singleResult = subWide[WIDTH-1:0];
                singleCarry  = subWide[WIDTH];
                singleOvf    = (bus.BusA[WIDTH-1] != bus.BusB[WIDTH-1]) &
                               (subWide[WIDTH-1] != bus.BusA[WIDTH-1]);
            end
            OP_PASS: singleResult = bus.BusB;
            OP_SHL: begin
                singleResult = shlWide[WIDTH-1:0];
                singleCarry  = shlWide[WIDTH];
            end
            OP_SHR: begin
                singleResult = shrWide[WIDTH:1];
                singleCarry  = shrWide[0];
            end
            OP_MUL: singleResult = '0;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV, OP_REM: singleResult = '0;
`endif
            default: singleIllegal = 1'b1;
        endcase
        singleFlags.z = (singleResult == '0) & ~singleIllegal;
        singleFlags.n = singleResult[WIDTH-1];
        singleFlags.c = singleCarry;
        singleFlags.v = singleOvf;
    end

    alu_seq_muldiv #(
        .WIDTH(WIDTH)
    ) uMulDiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (accept & isIter),
        .op        (bus.Operation),
        .a         (bus.BusA),
        .b         (bus.BusB),
        .done      (mdDone),
        .result    (mdResult),
        .divByZero (mdDivByZero)
    );

    assign mdFlags.z = (mdResult == '0);
    assign mdFlags.n = mdResult[WIDTH-1];
    assign mdFlags.c = 1'b0;
    assign mdFlags.v = mdDivByZero;

    // Result registers only move on a new accept or on completion, so they
    // hold steady while a result waits for OutReady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg     <= ST_IDLE;
            outValidReg  <= 1'b0;
            busCReg      <= '0;
            flagsReg     <= '0;
            opIllegalReg <= 1'b0;
        end else begin
            case (stateReg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (isIter) begin
                            stateReg    <= ST_BUSY;
                            outValidReg <= 1'b0;
                        end else begin
                            stateReg     <= ST_DONE;
                            outValidReg  <= 1'b1;
                            busCReg      <= singleResult;
                            flagsReg     <= singleFlags;
                            opIllegalReg <= singleIllegal;
                        end
                    end else if ((stateReg == ST_DONE) && bus.OutReady) begin
                        stateReg    <= ST_IDLE;
                        outValidReg <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (mdDone) begin
                        stateReg     <= ST_DONE;
                        outValidReg  <= 1'b1;
                        busCReg      <= mdResult;
                        flagsReg     <= mdFlags;
                        opIllegalReg <= 1'b0;
                    end
                end
                default: stateReg <= ST_IDLE;
            endcase
        end
    end

    assign bus.InReady   = inReady;
    assign bus.OutValid  = outValidReg;
    assign bus.BusC      = busCReg;
    assign bus.FlagZ     = flagsReg.z;
    assign bus.FlagN     = flagsReg.n;
    assign bus.FlagC     = flagsReg.c;
    assign bus.FlagV     = flagsReg.v;
    assign bus.OpIllegal = opIllegalReg;
endmodule
